// File: rtl/bp_pkg.sv
// bp_pkg: shared sizing defaults, tag width and the tracked control-flow entry type.
package bp_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_DEPTH = 8;
  localparam int TAG_W = $clog2(DEF_DEPTH);
  // Widest supported address; narrower XLEN values are zero-extended into the entry.
  localparam int ENT_W = 64;
  typedef struct packed {
    logic valid;
    logic resolved;
    logic [ENT_W-1:0] pc;
    logic pred_taken;
    logic [ENT_W-1:0] pred_target;
  } entry_t;
endpackage

// File: rtl/branch_check_if.sv
// branch_check_if: fetch allocation, execute resolve, commit and redirect signals.
interface branch_check_if
  import bp_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int TW = $clog2(DEPTH);
  logic alloc_valid1, alloc_valid2;
  logic [XLEN-1:0] alloc_pc1, alloc_pc2;
  logic alloc_pred_taken1, alloc_pred_taken2;
  logic [XLEN-1:0] alloc_pred_target1, alloc_pred_target2;
  logic alloc_ready;
  logic [TW-1:0] alloc_tag1, alloc_tag2;
  logic resolve_valid;
  logic [TW-1:0] resolve_tag;
  logic resolve_taken;
  logic [XLEN-1:0] resolve_target;
  logic commit_valid, commit_ready;
  logic mispredict;
  logic [XLEN-1:0] actual_target_address;
  logic [TW-1:0] flush_tag;
  logic [TW:0] count;
  modport master (
    output alloc_valid1, alloc_valid2, alloc_pc1, alloc_pc2,
    output alloc_pred_taken1, alloc_pred_taken2, alloc_pred_target1, alloc_pred_target2,
    output resolve_valid, resolve_tag, resolve_taken, resolve_target, commit_valid,
    input alloc_ready, alloc_tag1, alloc_tag2, commit_ready,
    input mispredict, actual_target_address, flush_tag, count
  );
  modport slave (
    input alloc_valid1, alloc_valid2, alloc_pc1, alloc_pc2,
    input alloc_pred_taken1, alloc_pred_taken2, alloc_pred_target1, alloc_pred_target2,
    input resolve_valid, resolve_tag, resolve_taken, resolve_target, commit_valid,
    output alloc_ready, alloc_tag1, alloc_tag2, commit_ready,
    output mispredict, actual_target_address, flush_tag, count
  );
endinterface

// File: rtl/br_outcome_cmp.sv
// br_outcome_cmp: actual next PC of a resolved branch and whether the prediction missed.
module br_outcome_cmp #(
  parameter int XLEN = 32,
  parameter int W = 64
) (
  input  logic [W-1:0]    pc,
  input  logic            pred_taken,
  input  logic [W-1:0]    pred_target,
  input  logic            res_taken,
  input  logic [W-1:0]    res_target,
  output logic [XLEN-1:0] actual,
  output logic            mispredict
);
  always_comb begin
    actual = XLEN'(res_taken ? res_target : pc + W'(4));
    mispredict = (res_taken != pred_taken) || (res_taken && res_target != pred_target);
  end
endmodule

// File: rtl/branch_check.sv
// branch_check: tracks in-flight control-flow instructions in a circular buffer,
// detects mispredicts at resolve and squashes younger entries with a one-cycle redirect.
module branch_check
  import bp_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic CLK,
  input logic reset,
  branch_check_if.slave bus
);
  localparam int TW = $clog2(DEPTH);
  localparam int PW = TW + 1;
  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, count;
  logic mis_q, mis_d;
  logic [XLEN-1:0] act_q, act_d, actual;
  logic [TW-1:0] flush_q, flush_d;
  logic [TW-1:0] head_idx, tail_idx, tag2, rtag, roff;
  entry_t rent;
  logic res_ok, cmp_mis, mis_det, acc, commit;
  logic [1:0] n_acc;
  assign head_idx = head_q[TW-1:0];
  assign tail_idx = tail_q[TW-1:0];
  assign count = tail_q - head_q;
  assign rtag = bus.resolve_tag;
  assign rent = ent_q[rtag];
  assign roff = rtag - head_idx;
  assign res_ok = bus.resolve_valid && rent.valid && !rent.resolved;
  assign mis_det = res_ok && cmp_mis;
  // Readiness uses the pre-commit occupancy, so a commit never frees room the same cycle.
  assign bus.alloc_ready = (PW'(DEPTH) - count) >= PW'(2);
  assign acc = bus.alloc_ready && !mis_q && !mis_det;
  assign bus.commit_ready = ent_q[head_idx].valid && ent_q[head_idx].resolved;
  assign commit = bus.commit_valid && bus.commit_ready;
  assign tag2 = bus.alloc_valid1 ? tail_idx + TW'(1) : tail_idx;
  assign bus.alloc_tag1 = tail_idx;
  assign bus.alloc_tag2 = tag2;
  assign n_acc = {1'b0, bus.alloc_valid1} + {1'b0, bus.alloc_valid2};
  assign bus.mispredict = mis_q;
  assign bus.actual_target_address = act_q;
  assign bus.flush_tag = flush_q;
  assign bus.count = count;
  br_outcome_cmp #(.XLEN(XLEN), .W(ENT_W)) u_cmp (
    .pc          (rent.pc),
    .pred_taken  (rent.pred_taken),
    .pred_target (rent.pred_target),
    .res_taken   (bus.resolve_taken),
    .res_target  (ENT_W'(bus.resolve_target)),
    .actual      (actual),
    .mispredict  (cmp_mis)
  );
  always_comb begin
    ent_d = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (res_ok) ent_d[rtag].resolved = 1'b1;
    // Entries further from head than the mispredicted one are younger and get squashed.
    if (mis_det) begin
      tail_d = head_q + PW'(roff) + PW'(1);
      for (int i = 0; i < DEPTH; i++)
        if (TW'(TW'(i) - head_idx) > roff) ent_d[i] = '0;
    end
    if (commit) begin
      ent_d[head_idx].valid = 1'b0;
      ent_d[head_idx].resolved = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (acc && bus.alloc_valid1)
      ent_d[tail_idx] = entry_t'{valid: 1'b1, resolved: 1'b0, pc: ENT_W'(bus.alloc_pc1),
                                 pred_taken: bus.alloc_pred_taken1,
                                 pred_target: ENT_W'(bus.alloc_pred_target1)};
    if (acc && bus.alloc_valid2)
      ent_d[tag2] = entry_t'{valid: 1'b1, resolved: 1'b0, pc: ENT_W'(bus.alloc_pc2),
                             pred_taken: bus.alloc_pred_taken2,
                             pred_target: ENT_W'(bus.alloc_pred_target2)};
    if (acc) tail_d = tail_q + PW'(n_acc);
    mis_d = mis_det;
    act_d = mis_det ? actual : '0;
    flush_d = mis_det ? rtag : '0;
  end
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      ent_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      mis_q <= 1'b0;
      act_q <= '0;
      flush_q <= '0;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      mis_q <= mis_d;
      act_q <= act_d;
      flush_q <= flush_d;
    end
endmodule

// File: tb/tb_branch_check.sv
// tb_branch_check: directed scenarios plus random traffic checked against a queue model.
module tb_branch_check;
  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  typedef logic [XLEN-1:0] addr_t;
  typedef struct {
    int tag;
    addr_t pc;
    bit pt;
    addr_t ptgt;
    bit res;
  } m_ent_t;
  logic clk = 1'b0;
  logic rst;
  m_ent_t q[$];
  int m_tail, m_flush, n_chk, n_err;
  bit m_mis;
  addr_t m_act;
  always #5 clk = ~clk;
  branch_check_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  branch_check #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.CLK(clk), .reset(rst), .bus(bus));
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int find_tag(int t);
    foreach (q[i]) if (q[i].tag == t) return i;
    return -1;
  endfunction
  function automatic bit m_ready();
    return (DEPTH - q.size()) >= 2;
  endfunction
  function automatic bit m_cready();
    return (q.size() > 0) ? q[0].res : 1'b0;
  endfunction
  task automatic model_reset();
    q.delete();
    m_tail = 0;
    m_mis = 0;
    m_act = '0;
    m_flush = 0;
  endtask
  task automatic check_all();
    check("alloc_ready", bus.alloc_ready, m_ready());
    check("alloc_tag1", bus.alloc_tag1, m_tail);
    check("alloc_tag2", bus.alloc_tag2, bus.alloc_valid1 ? (m_tail + 1) % DEPTH : m_tail);
    check("commit_ready", bus.commit_ready, m_cready());
    check("count", bus.count, q.size());
    check("mispredict", bus.mispredict, m_mis);
    check("actual_target", bus.actual_target_address, m_act);
    check("flush_tag", bus.flush_tag, m_flush);
  endtask
  task automatic model_step();
    bit rdy, crdy, mis, was;
    addr_t act;
    int k;
    rdy = m_ready();
    crdy = m_cready();
    was = m_mis;
    mis = 0;
    act = '0;
    k = bus.resolve_valid ? find_tag(int'(bus.resolve_tag)) : -1;
    if (k >= 0 && !q[k].res) begin
      q[k].res = 1;
      act = bus.resolve_taken ? bus.resolve_target : q[k].pc + 32'd4;
      mis = (bus.resolve_taken != q[k].pt) || (bus.resolve_taken && bus.resolve_target != q[k].ptgt);
      if (mis) begin
        q = q[0:k];
        m_tail = (int'(bus.resolve_tag) + 1) % DEPTH;
      end
    end
    if (bus.commit_valid && crdy) void'(q.pop_front());
    if (rdy && !was && !mis) begin
      if (bus.alloc_valid1) begin
        q.push_back('{m_tail, bus.alloc_pc1, bus.alloc_pred_taken1, bus.alloc_pred_target1, 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (bus.alloc_valid2) begin
        q.push_back('{m_tail, bus.alloc_pc2, bus.alloc_pred_taken2, bus.alloc_pred_target2, 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    m_mis = mis;
    m_act = mis ? act : '0;
    m_flush = mis ? int'(bus.resolve_tag) : 0;
  endtask
  task automatic idle();
    bus.alloc_valid1 = 0;
    bus.alloc_valid2 = 0;
    bus.alloc_pc1 = '0;
    bus.alloc_pc2 = '0;
    bus.alloc_pred_taken1 = 0;
    bus.alloc_pred_taken2 = 0;
    bus.alloc_pred_target1 = '0;
    bus.alloc_pred_target2 = '0;
    bus.resolve_valid = 0;
    bus.resolve_tag = '0;
    bus.resolve_taken = 0;
    bus.resolve_target = '0;
    bus.commit_valid = 0;
  endtask
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
    idle();
  endtask
  task automatic do_reset();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  task automatic alloc1(addr_t pc, bit pt, addr_t tgt);
    bus.alloc_valid1 = 1;
    bus.alloc_pc1 = pc;
    bus.alloc_pred_taken1 = pt;
    bus.alloc_pred_target1 = tgt;
  endtask
  task automatic alloc2(addr_t pc, bit pt, addr_t tgt);
    bus.alloc_valid2 = 1;
    bus.alloc_pc2 = pc;
    bus.alloc_pred_taken2 = pt;
    bus.alloc_pred_target2 = tgt;
  endtask
  task automatic resolve(int tag, bit tk, addr_t tgt);
    bus.resolve_valid = 1;
    bus.resolve_tag = tag[$clog2(DEPTH)-1:0];
    bus.resolve_taken = tk;
    bus.resolve_target = tgt;
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    @(negedge clk);
    do_reset();
    #1;
    check("rst_ready", bus.alloc_ready, 1);
    check("rst_count", bus.count, 0);
    check("rst_mis", bus.mispredict, 0);
    // correct taken prediction, then retire
    alloc1(32'h100, 1, 32'h200); tick();
    resolve(0, 1, 32'h200); tick();
    check("s1_mis", bus.mispredict, 0);
    check("s1_cready", bus.commit_ready, 1);
    bus.commit_valid = 1; tick();
    check("s1_count", bus.count, 0);
    // predicted not taken but taken
    alloc1(32'h40, 0, 32'h0); tick();
    resolve(1, 1, 32'h80); tick();
    check("s2_mis", bus.mispredict, 1);
    check("s2_act", bus.actual_target_address, 32'h80);
    check("s2_flush", bus.flush_tag, 1);
    tick();
    check("s2_mis_off", bus.mispredict, 0);
    check("s2_act_off", bus.actual_target_address, 0);
    bus.commit_valid = 1; tick();
    // squash of younger tags after a wrong taken prediction
    do_reset();
    alloc1(32'h0, 0, 32'h0); alloc2(32'h10, 1, 32'h50); tick();
    alloc1(32'h20, 0, 32'h0); alloc2(32'h30, 1, 32'h90); tick();
    resolve(1, 0, 32'h0); tick();
    check("s3_act", bus.actual_target_address, 32'h14);
    check("s3_flush", bus.flush_tag, 1);
    check("s3_count", bus.count, 2);
    check("s3_tail", bus.alloc_tag1, 2);
    resolve(3, 1, 32'h90); tick();
    check("s3_ign_mis", bus.mispredict, 0);
    check("s3_ign_count", bus.count, 2);
    // fill, blocked alloc, commit while full, tail wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc1(addr_t'(i * 8), 0, 32'h0); alloc2(addr_t'(i * 8 + 4), 0, 32'h0); tick();
    end
    check("s4_full_ready", bus.alloc_ready, 0);
    check("s4_full_count", bus.count, 8);
    check("s4_wrap_tag", bus.alloc_tag1, 0);
    alloc1(32'h500, 0, 32'h0); tick();
    check("s4_drop", bus.count, 8);
    resolve(0, 0, 32'h0); tick();
    bus.commit_valid = 1; alloc1(32'h600, 0, 32'h0);
    #1 check("s4_pre_edge", bus.count, 8);
    tick();
    check("s4_post_commit", bus.count, 7);
    check("s4_still_blocked", bus.alloc_ready, 0);
    resolve(1, 0, 32'h0); tick();
    bus.commit_valid = 1; tick();
    alloc1(32'h700, 0, 32'h0); tick();
    check("s4_wrap_adv", bus.alloc_tag1, 1);
    // out-of-order resolve, in-order commit
    do_reset();
    alloc1(32'h0, 0, 32'h0); alloc2(32'h4, 0, 32'h0); tick();
    alloc1(32'h8, 0, 32'h0); tick();
    resolve(2, 0, 32'h0); tick();
    check("s5_block", bus.commit_ready, 0);
    bus.commit_valid = 1; tick();
    check("s5_no_commit", bus.count, 3);
    resolve(0, 0, 32'h0); tick();
    check("s5_ready0", bus.commit_ready, 1);
    bus.commit_valid = 1; tick();
    check("s5_block1", bus.commit_ready, 0);
    resolve(1, 0, 32'h0); tick();
    bus.commit_valid = 1; tick();
    check("s5_ready2", bus.commit_ready, 1);
    bus.commit_valid = 1; tick();
    check("s5_empty", bus.count, 0);
    // reset in the pulse cycle
    alloc1(32'h40, 0, 32'h0); tick();
    resolve(m_tail - 1 < 0 ? DEPTH - 1 : m_tail - 1, 1, 32'h80); tick();
    check("s6_pulse", bus.mispredict, 1);
    rst = 1;
    #1;
    check("s6_async_mis", bus.mispredict, 0);
    check("s6_async_count", bus.count, 0);
    check("s6_async_act", bus.actual_target_address, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(1, 0) == 1) alloc1($urandom & ~32'h3, 1'($urandom), $urandom & ~32'h3);
      if ($urandom_range(1, 0) == 1) alloc2($urandom & ~32'h3, 1'($urandom), $urandom & ~32'h3);
      if ($urandom_range(1, 0) == 1) begin
        if (q.size() > 0 && $urandom_range(3, 0) != 0) begin
          int k;
          k = $urandom_range(q.size() - 1, 0);
          if ($urandom_range(3, 0) != 0) resolve(q[k].tag, q[k].pt, q[k].ptgt);
          else resolve(q[k].tag, 1'($urandom), $urandom & ~32'h3);
        end else resolve($urandom_range(DEPTH - 1, 0), 1'($urandom), $urandom);
      end
      bus.commit_valid = 1'($urandom);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/branch_check.md
BRANCH_CHECK -- requirements
Module: branch_check

Interface
REQ-001 SHALL have parameter XLEN, default 32: address width.
REQ-002 SHALL have parameter DEPTH, default 8: in-flight control-flow entries; power of two, at least 4.
REQ-003 SHALL have port CLK  input  1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have ports alloc_valid1/alloc_valid2  input  1 each: fetch slot 1/2 holds a control-flow instruction to track.
REQ-006 SHALL have ports alloc_pc1/alloc_pc2  input  XLEN each: instruction address per slot.
REQ-007 SHALL have ports alloc_pred_taken1/2 (input, 1) and alloc_pred_target1/2 (input, XLEN): fetch-time prediction per slot.
REQ-008 SHALL have port alloc_ready  output  1: high when at least 2 entries are free.
REQ-009 SHALL have ports alloc_tag1/alloc_tag2  output  log2(DEPTH) each: tags granted this cycle; combinational from tail.
REQ-010 SHALL have ports resolve_valid (input, 1), resolve_tag (input, log2(DEPTH)), resolve_taken (input, 1) and resolve_target (input, XLEN): execute-stage outcome, any order.
REQ-011 SHALL have ports commit_valid (input, 1) and commit_ready (output, 1): retire head entry; commit_ready means the head is valid and resolved.
REQ-012 SHALL have ports mispredict (output, 1), actual_target_address (output, XLEN) and flush_tag (output, log2(DEPTH)): registered redirect to fetch PC and squash boundary.
REQ-013 SHALL have port count  output  log2(DEPTH)+1: occupied entries.

Function
REQ-014 SHALL keep head/tail pointers with one extra wrap bit: full when the indices match and the wrap bits differ; empty when both are equal.
REQ-015 SHALL write accepted allocations in slot order at tail: slot1 gets tag tail, slot2 gets tail+1 if slot1 valid, else tail. Tail SHALL advance by the number accepted, modulo DEPTH.
REQ-016 SHALL accept allocations only when alloc_ready=1, and SHALL drop them when a mispredict is detected this cycle or when mispredict is high.
REQ-017 SHALL, on resolve_valid to a valid, unresolved entry, compute actual = resolve_taken ? resolve_target : pc+4, with arithmetic modulo 2^XLEN.
REQ-018 SHALL detect a mispredict when resolve_taken != pred_taken, or when both are taken and resolve_target != pred_target.
REQ-019 SHALL, on detection, set mispredict=1 for exactly one cycle starting next cycle, with actual_target_address=actual and flush_tag=resolve_tag.
REQ-020 SHALL, on detection, set tail <= resolve_tag+1 with the wrap bit recomputed relative to head, and invalidate all younger entries that same edge.
REQ-021 SHALL mark the resolved entry resolved in every case, including a mispredict.
REQ-022 SHALL ignore a resolve to an invalid, already-resolved or squashed tag, with no state change.
REQ-023 SHALL retire the head when commit_valid and commit_ready are both high, advancing head by 1; commit_valid while commit_ready=0 SHALL be ignored.
REQ-024 SHALL apply alloc, resolve and commit in the same cycle independently; when full, a commit SHALL NOT enable an allocation in the same cycle.
REQ-025 SHALL hold mispredict, actual_target_address and flush_tag at 0 except during the pulse cycle.

Reset
REQ-026 SHALL, while reset is high, asynchronously clear head, tail, all valid/resolved bits, mispredict, actual_target_address, flush_tag and count; alloc_ready=1 at reset.
REQ-027 SHALL, on reset asserted mid-pulse or mid-flush, abort the operation immediately with no residual mispredict.

Structure
REQ-028 SHALL put the XLEN and DEPTH defaults, the tag width and the entry struct (valid, resolved, pc, pred_taken, pred_target) in shared package bp_pkg.
REQ-029 SHALL implement the REQ-017/REQ-018 comparison as combinational sub-module br_outcome_cmp.

Verification
REQ-030 SHALL cover: alloc pc=0x100, pred taken→0x200, resolve taken, target 0x200 → no mispredict; commit_ready=1; commit → count=0.
REQ-031 SHALL cover: alloc pc=0x40 predicted not taken, resolve taken, target 0x80 → next cycle mispredict=1, actual_target_address=0x80, for one cycle.
REQ-032 SHALL cover: alloc tags 0..3, resolve tag1 wrong (pred taken, actual not taken, pc=0x10) → actual_target_address=0x14, flush_tag=1, count=2, later resolve to tag3 ignored.
REQ-033 SHALL cover: fill 8 entries → alloc_ready=0; alloc ignored; one commit → entries unchanged until next cycle; wrap tail 7→0 verified.
REQ-034 SHALL cover: resolve tag2 before tag0 → commit_ready=0 until tag0 resolved; then in-order commit of tags 0, 1 (after resolve), 2.
REQ-035 SHALL cover: reset asserted in the mispredict pulse cycle → mispredict=0 and count=0 immediately, without waiting for a clock edge.
